// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types, limits and helpers for the reset sequencer.
//   rst_seq_state_t   : sequencer state (IDLE, HOLD, REL, RUN)
//   RST_SEQ_MIN_SYNC  : smallest legal synchroniser depth
//   RST_SEQ_MIN_HOLD  : smallest legal hold length
//   rst_seq_max       : integer max, used to size the shared counter
//   rst_seq_params_ok : elaboration-time parameter legality check
package rst_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        REL  = 2'd2,
        RUN  = 2'd3
    } rst_seq_state_t;

    localparam int RST_SEQ_MIN_SYNC = 2;
    localparam int RST_SEQ_MIN_HOLD = 1;

    function automatic int rst_seq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit rst_seq_params_ok(input int sync_stages, input int hold_cycles,
                                             input int nch, input int stagger);
        return (sync_stages >= RST_SEQ_MIN_SYNC) && (hold_cycles >= RST_SEQ_MIN_HOLD) &&
               (nch >= 1) && (stagger >= 1);
    endfunction

endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if: downstream reset bundle of the sequencer.
//   rst_n_o    : per-channel active-low reset, bit 0 releases first
//   done_o     : all channels released
//   sw_rst_req : software reset request (only when RST_SEQ_SWRST_EN is defined)
// Modports: master = sequencer side, slave = consumer side.
// Handshake: none; these are level signals. done_o and rst_n_o are registered
// by the master; sw_rst_req is a level sampled by the master on every clk edge.
interface rst_seq_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] rst_n_o;
    logic           done_o;
`ifdef RST_SEQ_SWRST_EN
    logic           sw_rst_req;

    modport master (output rst_n_o, output done_o, input  sw_rst_req);
    modport slave  (input  rst_n_o, input  done_o, output sw_rst_req);
`else
    modport master (output rst_n_o, output done_o);
    modport slave  (input  rst_n_o, input  done_o);
`endif
endinterface

// File: rtl/rst_seq_sync.sv
// rst_sync: reset-deassertion synchroniser. A chain of STAGES flops with
// asynchronous clear and data tied to 1; sync_q rises STAGES edges after
// rst_n is first sampled high and drops immediately when rst_n goes low.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   sync_q : synchronised release
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic sync_q
);
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_q = chain_q[STAGES-1];
endmodule

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer. Asserts all channel resets asynchronously on
// rst_n low, synchronises the release, holds HOLD_CYCLES cycles, then releases
// NCH channels STAGGER cycles apart and raises done_o.
// Optional feature macro: RST_SEQ_SWRST_EN adds bus.sw_rst_req, which restarts
// the sequence from HOLD when sampled high in HOLD, REL or RUN.
//   clk         : clock
//   rst_n       : asynchronous active-low chip reset
//   bus         : rst_seq_if master (rst_n_o, done_o, optional sw_rst_req)
//   dbg_state_o : current sequencer state
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NCH         = 4,
    parameter int STAGGER     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    rst_seq_if.master      bus,
    output rst_seq_state_t dbg_state_o
);
    localparam int CNT_W = $clog2(rst_seq_max(HOLD_CYCLES, STAGGER) + 1);
    localparam int CH_W  = $clog2(NCH + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
    localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NCH - 1);

    if (!rst_seq_params_ok(SYNC_STAGES, HOLD_CYCLES, NCH, STAGGER)) begin : g_bad_params
        $error("rst_seq: illegal parameters");
    end

    logic sync_q;
    logic sw_req;

    rst_seq_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [NCH-1:0]   rst_n_o_q, rst_n_o_d;
    logic             done_q, done_d;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync_q (sync_q)
    );

`ifdef RST_SEQ_SWRST_EN
    assign sw_req = bus.sw_rst_req;
`else
    assign sw_req = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        rst_n_o_d = rst_n_o_q;
        done_d    = done_q;

        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    rst_n_o_d[0] = 1'b1;
                    cnt_d        = '0;
                    if (NCH == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = REL;
                        ch_d    = CH_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REL: begin
                if (cnt_q == STAGGER_LAST) begin
                    // Decoded loop keeps the index width independent of CH_W.
                    for (int i = 0; i < NCH; i++) begin
                        if (ch_q == CH_W'(i)) begin
                            rst_n_o_d[i] = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Software restart wins over the normal progression but is ignored
        // until the synchronised release has left IDLE.
        if (sw_req && (state_q != IDLE)) begin
            state_d   = HOLD;
            cnt_d     = '0;
            ch_d      = '0;
            rst_n_o_d = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            rst_n_o_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            rst_n_o_q <= rst_n_o_d;
            done_q    <= done_d;
        end
    end

    assign bus.rst_n_o = rst_n_o_q;
    assign bus.done_o  = done_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed bench for rst_seq.
//   dut_a : SYNC_STAGES=2, HOLD_CYCLES=4, NCH=3, STAGGER=2
//   dut_b : SYNC_STAGES=3, HOLD_CYCLES=1, NCH=1, STAGGER=1
// Software-request scenarios are built only with RST_SEQ_SWRST_EN.
module tb_rst_seq;
    import rst_seq_pkg::*;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    rst_seq_state_t state_a;
    rst_seq_state_t state_b;

    int total;
    int bad;

    rst_seq_if #(.NCH(3)) bus_a ();
    rst_seq_if #(.NCH(1)) bus_b ();

    rst_seq #(.SYNC_STAGES(2), .HOLD_CYCLES(4), .NCH(3), .STAGGER(2)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n_a),
        .bus         (bus_a.master),
        .dbg_state_o (state_a)
    );

    rst_seq #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .NCH(1), .STAGGER(1)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n_b),
        .bus         (bus_b.master),
        .dbg_state_o (state_b)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected channel vector after edge e when channel 0 releases at 'first'.
    function automatic logic [2:0] exp_chan(input int e, input int first);
        logic [2:0] r;
        r = 3'b000;
        if (e >= first)     r[0] = 1'b1;
        if (e >= first + 2) r[1] = 1'b1;
        if (e >= first + 4) r[2] = 1'b1;
        return r;
    endfunction

    task automatic hold_reset_a();
        rst_n_a = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Releases rst_n_a between edges so the next posedge is edge 1.
    task automatic release_a();
        @(negedge clk);
        rst_n_a = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (bus_a.rst_n_o !== 3'b000 || bus_a.done_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_a_t0 got=%b/%b exp=000/0", bus_a.rst_n_o, bus_a.done_o);
        end
        total++;
        if (state_a !== IDLE) begin
            bad++;
            $display("FAIL reset_a_state got=%0d exp=%0d", state_a, IDLE);
        end
        total++;
        if (bus_b.rst_n_o !== 1'b0 || bus_b.done_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_b_t0 got=%b/%b exp=0/0", bus_b.rst_n_o, bus_b.done_o);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            total++;
            if (bus_a.rst_n_o !== 3'b000 || bus_a.done_o !== 1'b0 || state_a !== IDLE) begin
                bad++;
                $display("FAIL reset_a_held got=%b/%b exp=000/0", bus_a.rst_n_o, bus_a.done_o);
            end
        end
    endtask

    task automatic test_power_on();
        hold_reset_a();
        release_a();
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus_a.rst_n_o !== exp_chan(e, 7) || bus_a.done_o !== (e >= 11)) begin
                bad++;
                $display("FAIL power_on edge=%0d got=%b/%b exp=%b/%b", e, bus_a.rst_n_o,
                         bus_a.done_o, exp_chan(e, 7), (e >= 11));
            end
            if (e == 2 || e == 3 || e == 7 || e == 11) begin
                rst_seq_state_t exp_st;
                exp_st = (e == 2) ? IDLE : (e == 3) ? HOLD : (e == 7) ? REL : RUN;
                total++;
                if (state_a !== exp_st) begin
                    bad++;
                    $display("FAIL power_on_state edge=%0d got=%0d exp=%0d", e, state_a, exp_st);
                end
            end
        end
    endtask

    task automatic test_mid_assert();
        hold_reset_a();
        release_a();
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus_a.rst_n_o !== exp_chan(e, 7)) begin
                bad++;
                $display("FAIL mid_pre edge=%0d got=%b exp=%b", e, bus_a.rst_n_o, exp_chan(e, 7));
            end
        end
        #2;
        rst_n_a = 1'b0;
        #1;
        total++;
        if (bus_a.rst_n_o !== 3'b000 || bus_a.done_o !== 1'b0 || state_a !== IDLE) begin
            bad++;
            $display("FAIL mid_async got=%b/%b exp=000/0", bus_a.rst_n_o, bus_a.done_o);
        end
        repeat (2) @(posedge clk);
        release_a();
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus_a.rst_n_o !== exp_chan(e, 7) || bus_a.done_o !== (e >= 11)) begin
                bad++;
                $display("FAIL mid_rerun edge=%0d got=%b/%b exp=%b/%b", e, bus_a.rst_n_o,
                         bus_a.done_o, exp_chan(e, 7), (e >= 11));
            end
        end
    endtask

    // Entered just after an edge with dut_a in RUN.
    task automatic test_glitch();
        total++;
        if (bus_a.rst_n_o !== 3'b111 || bus_a.done_o !== 1'b1) begin
            bad++;
            $display("FAIL glitch_pre got=%b/%b exp=111/1", bus_a.rst_n_o, bus_a.done_o);
        end
        #2;
        rst_n_a = 1'b0;
        #1;
        total++;
        if (bus_a.rst_n_o !== 3'b000 || bus_a.done_o !== 1'b0) begin
            bad++;
            $display("FAIL glitch_async got=%b/%b exp=000/0", bus_a.rst_n_o, bus_a.done_o);
        end
        #2;
        rst_n_a = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus_a.rst_n_o !== exp_chan(e, 7) || bus_a.done_o !== (e >= 11)) begin
                bad++;
                $display("FAIL glitch_rerun edge=%0d got=%b/%b exp=%b/%b", e, bus_a.rst_n_o,
                         bus_a.done_o, exp_chan(e, 7), (e >= 11));
            end
        end
    endtask

    task automatic test_nch1();
        rst_n_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus_b.rst_n_o !== (e >= 5) || bus_b.done_o !== (e >= 5)) begin
                bad++;
                $display("FAIL nch1 edge=%0d got=%b/%b exp=%b/%b", e, bus_b.rst_n_o,
                         bus_b.done_o, (e >= 5), (e >= 5));
            end
            if (e == 3 || e == 4) begin
                total++;
                if (state_b !== ((e == 3) ? IDLE : HOLD)) begin
                    bad++;
                    $display("FAIL nch1_state edge=%0d got=%0d", e, state_b);
                end
            end
        end
    endtask

`ifdef RST_SEQ_SWRST_EN
    task automatic test_sw_pulse();
        hold_reset_a();
        // Request is high at edges 1..2 while still in IDLE: must be ignored.
        bus_a.sw_rst_req = 1'b1;
        release_a();
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (e == 2)  bus_a.sw_rst_req = 1'b0;
            if (e == 19) bus_a.sw_rst_req = 1'b1;
            if (e == 20) bus_a.sw_rst_req = 1'b0;
            total++;
            if (e < 20) begin
                if (bus_a.rst_n_o !== exp_chan(e, 7) || bus_a.done_o !== (e >= 11)) begin
                    bad++;
                    $display("FAIL sw_pulse_pre edge=%0d got=%b/%b exp=%b/%b", e,
                             bus_a.rst_n_o, bus_a.done_o, exp_chan(e, 7), (e >= 11));
                end
            end else begin
                if (bus_a.rst_n_o !== exp_chan(e, 24) || bus_a.done_o !== (e >= 28)) begin
                    bad++;
                    $display("FAIL sw_pulse edge=%0d got=%b/%b exp=%b/%b", e, bus_a.rst_n_o,
                             bus_a.done_o, exp_chan(e, 24), (e >= 28));
                end
            end
        end
    endtask

    task automatic test_sw_hold();
        hold_reset_a();
        release_a();
        for (int e = 1; e <= 28; e++) begin
            @(posedge clk);
            #1;
            if (e == 8)  bus_a.sw_rst_req = 1'b1;
            if (e == 18) bus_a.sw_rst_req = 1'b0;
            total++;
            if (e < 9) begin
                if (bus_a.rst_n_o !== exp_chan(e, 7)) begin
                    bad++;
                    $display("FAIL sw_hold_pre edge=%0d got=%b exp=%b", e, bus_a.rst_n_o,
                             exp_chan(e, 7));
                end
            end else begin
                if (bus_a.rst_n_o !== exp_chan(e, 22) || bus_a.done_o !== (e >= 26)) begin
                    bad++;
                    $display("FAIL sw_hold edge=%0d got=%b/%b exp=%b/%b", e, bus_a.rst_n_o,
                             bus_a.done_o, exp_chan(e, 22), (e >= 26));
                end
                if (e >= 9 && e <= 18) begin
                    total++;
                    if (state_a !== HOLD) begin
                        bad++;
                        $display("FAIL sw_hold_state edge=%0d got=%0d exp=%0d", e, state_a, HOLD);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        total   = 0;
        bad     = 0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
`ifdef RST_SEQ_SWRST_EN
        bus_a.sw_rst_req = 1'b0;
        bus_b.sw_rst_req = 1'b0;
`endif
        test_reset();
        test_power_on();
        test_mid_assert();
        test_glitch();
        test_nch1();
`ifdef RST_SEQ_SWRST_EN
        test_sw_pulse();
        test_sw_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer: asserts all outputs asynchronously and releases them synchronously. Takes the chip-level asynchronous reset, synchronises its deassertion into `clk`, and holds for a programmable number of cycles. It then releases `NCH` downstream reset channels one after another, `STAGGER` cycles apart. It sits between the pad/POR reset and the per-domain reset nets of the core, replacing hand-built two-flop reset chains.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth; must be ≥2.
- `HOLD_CYCLES`, default 16: cycles spent in HOLD before channel 0 releases; must be ≥1.
- `NCH`, default 4: number of reset channels; must be ≥1.
- `STAGGER`, default 4: cycles between consecutive channel releases; must be ≥1.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sw_rst_req`  in  1  synchronous software reset request, active-high. Present only with `RST_SEQ_SWRST_EN`.
- `rst_n_o`  out  NCH  per-channel active-low reset. Bit 0 releases first.
- `done_o`  out  1  high when all channels are released (state RUN).

## Operation
- States (package enum): IDLE, HOLD, REL, RUN. One counter `cnt`, width `$clog2(max(HOLD_CYCLES,STAGGER)+1)`. One channel index `ch`, width `$clog2(NCH+1)`.
- `rst_n` low:
  - Immediately, with no clock: state=IDLE, `cnt`=0, `ch`=0, synchroniser cleared, `rst_n_o`=0, `done_o`=0.
  - Any low pulse, however short, produces full reassertion and a full rerun of the sequence.
- IDLE: wait for synchroniser output `sync_q`. When `sync_q`=1, go to HOLD with `cnt`=0.
- HOLD: increment `cnt` each edge. At the edge where `cnt`==HOLD_CYCLES-1:
  - set `rst_n_o[0]`=1;
  - if NCH==1, go to RUN;
  - otherwise go to REL with `cnt`=0 and `ch`=1.
- REL: increment `cnt`. At the edge where `cnt`==STAGGER-1:
  - set `rst_n_o[ch]`=1 and `cnt`=0;
  - if `ch`==NCH-1, go to RUN; otherwise increment `ch`.
- RUN: `done_o`=1 and all `rst_n_o` bits are 1. The block stays in RUN until `rst_n` goes low or a software request arrives.
- Released channel bits stay released; bits change only through the rules above.

## Timing
- Number edges 1, 2, … starting with the first `clk` edge that samples `rst_n` high.
- `sync_q` is 1 after edge SYNC_STAGES. HOLD is entered at edge SYNC_STAGES+1.
- Channel k releases after edge SYNC_STAGES+1+HOLD_CYCLES+k·STAGGER.
- `done_o` rises on the same edge as the release of channel NCH-1.
- Assertion is asynchronous. Deassertion is always synchronous to `clk`, and all outputs are registered.
- `rst_n` low in any state overrides everything, including a simultaneous `sw_rst_req`.

## Configuration
- `RST_SEQ_SWRST_EN` defined:
  - `sw_rst_req` port exists. It is sampled at each edge in HOLD, REL or RUN.
  - When sampled high, at that edge: all `rst_n_o` go to 0, `done_o` goes to 0, state goes to HOLD with `cnt`=0 and `ch`=0. The release sequence then repeats: channel k releases HOLD_CYCLES+k·STAGGER edges later.
  - A request during HOLD or REL restarts HOLD and re-asserts channels that were already released.
  - A request held high keeps the block in HOLD with all outputs 0.
  - Requests are ignored in IDLE.
- `RST_SEQ_SWRST_EN` undefined: the port is absent and the sequence runs only after `rst_n`.

## Structure
- `rst_seq_pkg` holds:
  - `rst_seq_state_t` enum (IDLE, HOLD, REL, RUN);
  - localparam minima `RST_SEQ_MIN_SYNC`=2 and `RST_SEQ_MIN_HOLD`=1;
  - an elaboration-time check function for the parameters.
- Sub-module `rst_sync`, parameter STAGES: a flop chain with asynchronous clear to 0 and data input tied to 1, producing `sync_q`. The FSM, counters and output registers stay in `rst_seq`. All of them use asynchronous clear on `rst_n`.

## Test plan
- Power-on release, with SYNC_STAGES=2, HOLD_CYCLES=4, NCH=3, STAGGER=2 and `rst_n` rising before edge 1: `rst_n_o` goes 3'b001 after edge 7, 3'b011 after edge 9, 3'b111 after edge 11. `done_o`=1 after edge 11.
- Same configuration, `rst_n` driven low between edges 8 and 9: `rst_n_o`=0 and `done_o`=0 with no clock edge. After `rst_n` returns high, the full sequence reruns with the timing above.
- `rst_n` glitch low for 0.3 of a clock period during RUN: all outputs drop asynchronously, then re-release at edges 7, 9, 11 counted from the first edge that samples `rst_n` high again.
- `RST_SEQ_SWRST_EN` defined, `sw_rst_req` pulsed at edge 20 in RUN: outputs are 0 after edge 20, then 3'b001 after 24, 3'b011 after 26, 3'b111 after 28 (with `done_o`).
- `RST_SEQ_SWRST_EN` defined, `sw_rst_req` held high for 10 edges from edge 9 (during REL): channel 0 re-asserts at edge 9 and all outputs stay 0 while the request is high. Channel 0 releases HOLD_CYCLES=4 edges after the last request edge.
- NCH=1, HOLD_CYCLES=1, SYNC_STAGES=3: `rst_n_o[0]` and `done_o` both rise after edge 5.
